amo_ctrl: RTL and testbench

//  Sequences RISC-V atomic memory operations (amo_t: LR/SC/SWAP/ADD/AND/OR/XOR/MAX/MAXU/MIN/MINU) from the LSU into the D-cache AMO port.

---
 rtl/amo_ctrl.sv | 144 ++++++++++++++
 tb/tb_amo_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/amo_ctrl.sv
// RISC-V AMO sequencer: LSU request -> commit/store-buffer gate -> single D-cache AMO -> writeback result.
// Optional feature: define AMO_CTRL_WATCHDOG_EN to add a WAIT_RSP timeout (ex_timeout_o).
module amo_ctrl #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            amo_valid_i,
   output logic            amo_ready_o,
   input  logic [3:0]      amo_op_i,
   input  logic [1:0]      amo_size_i,
   input  logic [XLEN-1:0] amo_addr_i,
   input  logic [XLEN-1:0] amo_operand_i,
   input  logic            commit_i,
   input  logic            sb_empty_i,
   output logic            req_valid_o,
   input  logic            req_ready_i,
   output logic [3:0]      req_op_o,
   output logic [1:0]      req_size_o,
   output logic [XLEN-1:0] req_addr_o,
   output logic [XLEN-1:0] req_data_o,
   input  logic            rsp_valid_i,
   input  logic [XLEN-1:0] rsp_data_i,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic            ex_illegal_o,
   output logic            ex_misalign_o,
   output logic            ex_timeout_o
);

   localparam logic [3:0] AMO_NONE = 4'd0;
   localparam logic [3:0] AMO_SC   = 4'd2;
   localparam logic [3:0] AMO_CAS1 = 4'd12;

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_WAIT_COMMIT = 3'd1;
   localparam logic [2:0] S_REQ         = 3'd2;
   localparam logic [2:0] S_WAIT_RSP    = 3'd3;
   localparam logic [2:0] S_DONE        = 3'd4;

   logic [2:0]      state;
   logic [3:0]      op_q;
   logic [1:0]      size_q;
   logic [XLEN-1:0] addr_q, data_q, result_q;
   logic            illegal_q, misalign_q, timeout_q;

   logic            in_word, in_illegal, in_misalign;
   logic [XLEN-1:0] in_data, rsp_result;

   // CAS1/CAS2 and the unassigned encodings above them are all rejected
   assign in_word     = (amo_size_i == 2'b10);
   assign in_illegal  = (amo_op_i == AMO_NONE) || (amo_op_i >= AMO_CAS1) || !amo_size_i[1];
   assign in_misalign = in_word ? (amo_addr_i[1:0] != 2'b00) : (amo_addr_i[2:0] != 3'b000);
   assign in_data     = in_word ? {{(XLEN-32){1'b0}}, amo_operand_i[31:0]} : amo_operand_i;

   always_comb begin
      rsp_result = rsp_data_i;
      if (op_q == AMO_SC)
         rsp_result = {{(XLEN-1){1'b0}}, rsp_data_i[0]};
      else if (size_q == 2'b10)
         rsp_result = {{(XLEN-32){rsp_data_i[31]}}, rsp_data_i[31:0]};
   end

`ifdef AMO_CTRL_WATCHDOG_EN
   logic [7:0] wd_cnt;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         op_q       <= '0;
         size_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         result_q   <= '0;
         illegal_q  <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
`ifdef AMO_CTRL_WATCHDOG_EN
         wd_cnt     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (amo_valid_i) begin
               op_q       <= amo_op_i;
               size_q     <= amo_size_i;
               addr_q     <= amo_addr_i;
               data_q     <= in_data;
               result_q   <= '0;
               illegal_q  <= in_illegal;
               misalign_q <= !in_illegal && in_misalign;
               timeout_q  <= 1'b0;
               state      <= (in_illegal || in_misalign) ? S_DONE : S_WAIT_COMMIT;
            end
            S_WAIT_COMMIT: begin
               if (flush_i)                     state <= S_IDLE;
               else if (commit_i && sb_empty_i) state <= S_REQ;
            end
            S_REQ: if (req_ready_i) begin
               state <= S_WAIT_RSP;
`ifdef AMO_CTRL_WATCHDOG_EN
               wd_cnt <= '0;
`endif
            end
            S_WAIT_RSP: begin
               if (rsp_valid_i) begin
                  result_q <= rsp_result;
                  state    <= S_DONE;
               end
`ifdef AMO_CTRL_WATCHDOG_EN
               else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  timeout_q <= 1'b1;
                  result_q  <= '0;
                  state     <= S_DONE;
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
`endif
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign amo_ready_o    = (state == S_IDLE);
   assign req_valid_o    = (state == S_REQ);
   assign req_op_o       = op_q;
   assign req_size_o     = size_q;
   assign req_addr_o     = addr_q;
   assign req_data_o     = data_q;
   assign result_valid_o = (state == S_DONE);
   assign result_o       = result_valid_o ? result_q : '0;
   assign ex_illegal_o   = result_valid_o && illegal_q;
   assign ex_misalign_o  = result_valid_o && misalign_q;
`ifdef AMO_CTRL_WATCHDOG_EN
   assign ex_timeout_o   = result_valid_o && timeout_q;
`else
   assign ex_timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_amo_ctrl.sv
// Directed bench for amo_ctrl: checks latency, exceptions, commit gating, flush, request stability, reset.
module tb_amo_ctrl;
   localparam int XLEN = 64;
   localparam logic [3:0] OP_LR = 4'd1, OP_SC = 4'd2, OP_SWAP = 4'd3, OP_ADD = 4'd4, OP_CAS1 = 4'd12;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            flush = 0, amo_valid = 0, amo_ready, commit = 0, sb_empty = 0;
   logic [3:0]      amo_op = 0;
   logic [1:0]      amo_size = 0;
   logic [XLEN-1:0] amo_addr = 0, amo_operand = 0;
   logic            req_valid, req_ready = 0;
   logic [3:0]      req_op;
   logic [1:0]      req_size;
   logic [XLEN-1:0] req_addr, req_data;
   logic            rsp_valid = 0;
   logic [XLEN-1:0] rsp_data = 0;
   logic            result_valid, ex_illegal, ex_misalign, ex_timeout;
   logic [XLEN-1:0] result;

   int n_assert = 0, n_fail = 0;
   bit req_seen, res_seen;

   always #5 clk = ~clk;

   amo_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(255)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .amo_valid_i(amo_valid), .amo_ready_o(amo_ready), .amo_op_i(amo_op), .amo_size_i(amo_size),
      .amo_addr_i(amo_addr), .amo_operand_i(amo_operand), .commit_i(commit), .sb_empty_i(sb_empty),
      .req_valid_o(req_valid), .req_ready_i(req_ready), .req_op_o(req_op), .req_size_o(req_size),
      .req_addr_o(req_addr), .req_data_o(req_data), .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data),
      .result_valid_o(result_valid), .result_o(result), .ex_illegal_o(ex_illegal),
      .ex_misalign_o(ex_misalign), .ex_timeout_o(ex_timeout)
   );

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      if (req_valid)    req_seen = 1'b1;
      if (result_valid) res_seen = 1'b1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] sz, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] d);
      amo_valid = 1; amo_op = op; amo_size = sz; amo_addr = a; amo_operand = d;
      step();
      amo_valid = 0;
   endtask

   initial begin
      #3;
      chk("rst_ready", amo_ready, 1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_req_addr", req_addr, 0);
      chk("rst_ex", {ex_illegal, ex_misalign, ex_timeout}, 0);
      #9 rst_n = 1;

      // AMO_ADDW, commit and sb_empty already high: REQ on the second cycle after accept
      commit = 1; sb_empty = 1;
      issue(OP_ADD, 2'b10, 64'h1000, 64'hABCD_0000_0000_0005);
      chk("addw_wait_ready", amo_ready, 0);
      chk("addw_wait_reqv", req_valid, 0);
      step();
      chk("addw_req_valid", req_valid, 1);
      chk("addw_req_op", req_op, OP_ADD);
      chk("addw_req_size", req_size, 2'b10);
      chk("addw_req_addr", req_addr, 64'h1000);
      chk("addw_req_data", req_data, 64'h5);
      req_ready = 1; step(); req_ready = 0;
      chk("addw_rsp_wait", req_valid, 0);
      rsp_valid = 1; rsp_data = 64'h0000_0000_FFFF_FFF0; step(); rsp_valid = 0;
      chk("addw_res_valid", result_valid, 1);
      chk("addw_result", result, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("addw_ex", {ex_illegal, ex_misalign, ex_timeout}, 0);
      step();
      chk("addw_pulse_end", result_valid, 0);
      chk("addw_idle_ready", amo_ready, 1);

      // misaligned SWAPD, then back-to-back illegal requests
      req_seen = 0;
      amo_valid = 1; amo_op = OP_SWAP; amo_size = 2'b11; amo_addr = 64'h1004; amo_operand = 64'h7;
      step();
      chk("swapd_res_valid", result_valid, 1);
      chk("swapd_misalign", ex_misalign, 1);
      chk("swapd_illegal", ex_illegal, 0);
      chk("swapd_result", result, 0);
      chk("swapd_done_ready", amo_ready, 0);
      amo_op = OP_CAS1;
      step();
      chk("b2b_idle_ready", amo_ready, 1);
      chk("b2b_idle_resv", result_valid, 0);
      step();
      chk("cas1_illegal", ex_illegal, 1);
      chk("cas1_no_misalign", ex_misalign, 0);
      amo_op = OP_ADD; amo_size = 2'b01; amo_addr = 64'h0;
      step(); step();
      chk("size01_illegal", ex_illegal, 1);
      chk("size01_result", result, 0);
      amo_valid = 0;
      step();
      chk("exc_no_req", req_seen, 0);

      // LRD gated by store buffer drain
      sb_empty = 0; commit = 1; req_seen = 0;
      issue(OP_LR, 2'b11, 64'h2000, 64'h0);
      repeat (6) step();
      chk("lrd_sb_gate", req_seen, 0);
      sb_empty = 1; step();
      chk("lrd_req_valid", req_valid, 1);
      chk("lrd_req_op", req_op, OP_LR);
      req_ready = 1; step(); req_ready = 0;
      rsp_valid = 1; rsp_data = 64'hDEAD; step(); rsp_valid = 0;
      chk("lrd_result", result, 64'hDEAD);
      step();

      // SCW flushed in WAIT_COMMIT with commit in the same cycle
      commit = 0; req_seen = 0; res_seen = 0;
      issue(OP_SC, 2'b10, 64'h3000, 64'h1);
      flush = 1; commit = 1; step(); flush = 0; commit = 0;
      chk("flush_ready", amo_ready, 1);
      step(); step();
      chk("flush_no_req", req_seen, 0);
      chk("flush_no_res", res_seen, 0);

      // SCW with req_ready stalled 3 cycles and a stray response during REQ
      commit = 1; sb_empty = 1;
      issue(OP_SC, 2'b10, 64'h4008, 64'hFFFF_FFFF_1234_5678);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("scw_stall_valid", req_valid, 1);
         chk("scw_stall_addr", req_addr, 64'h4008);
         chk("scw_stall_data", req_data, 64'h1234_5678);
         chk("scw_stall_op", req_op, OP_SC);
         rsp_valid = (i == 1); rsp_data = 64'h0;
         if (i < 2) step();
      end
      rsp_valid = 0;
      req_ready = 1; step(); req_ready = 0;
      rsp_valid = 1; rsp_data = 64'h0000_0000_8000_0001; step(); rsp_valid = 0;
      chk("scw_res_valid", result_valid, 1);
      chk("scw_result", result, 64'h1);
      step();

      // no response: watchdog timeout, or indefinite wait without it
      res_seen = 0;
      issue(OP_ADD, 2'b11, 64'h5000, 64'h9);
      step();
      req_ready = 1; step(); req_ready = 0;
`ifdef AMO_CTRL_WATCHDOG_EN
      begin
         int n = 0;
         while (!result_valid && n < 300) begin step(); n++; end
         chk("wd_cycles", 64'(n), 64'd255);
         chk("wd_timeout", ex_timeout, 1);
         chk("wd_result", result, 0);
         step();
         rsp_valid = 1; rsp_data = 64'h55; step(); rsp_valid = 0;
         chk("wd_stray_rsp", result_valid, 0);
         commit = 0;
         issue(OP_ADD, 2'b11, 64'h5000, 64'h9);
         commit = 1; step(); step();
         chk("wd_rearm_req", req_valid, 1);
      end
`else
      repeat (300) step();
      chk("nowd_no_result", res_seen, 0);
      chk("nowd_still_busy", amo_ready, 0);
      chk("nowd_ex_timeout", ex_timeout, 0);
`endif
      // async reset mid-operation
      #2 rst_n = 0;
      #1;
      chk("arst_ready", amo_ready, 1);
      chk("arst_req_valid", req_valid, 0);
      #2 rst_n = 1;
      req_seen = 0;
      repeat (3) step();
      chk("arst_no_reissue", req_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
